// File: rtl/usb_cmd_interpreter.sv
// usb_cmd_interpreter
// Command/response engine between the command-stream FIFO (from EP4) and the
// response FIFO (to EP8). It parses SYNC/CMD/DATA packets, performs register
// reads and writes on a local register file, and emits 3-word responses.
// Optional build macro: CMD_TIMEOUT_EN enables the mid-packet idle timeout.
module usb_cmd_interpreter #(
    parameter int          NUM_REGS       = 16,
    parameter logic [15:0] SYNC_WORD      = 16'hA5C3,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_fifo_empty,
    input  logic [15:0]              cmd_fifo_data,
    output logic                     cmd_fifo_re,
    input  logic                     rsp_fifo_full,
    output logic [15:0]              rsp_fifo_data,
    output logic                     rsp_fifo_we,
    input  logic [15:0]              status_in,
    output logic [NUM_REGS*16-1:0]   reg_out,
    output logic [7:0]               err_count,
    output logic                     busy
);

    localparam logic [8:0]  NREGS_9     = 9'(NUM_REGS);
    localparam logic [7:0]  STATUS_ADDR = 8'hFF;
    localparam logic [15:0] ERR_WORD    = 16'hDEAD;
    localparam logic [1:0]  OP_WRITE    = 2'b01;
    localparam logic [1:0]  OP_READ     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CMD,
        S_GET_DATA,
        S_EXEC,
        S_RSP0,
        S_RSP1,
        S_RSP2
    } state_t;

    state_t      state_q, state_d;
    logic        rd_pend_q;
    logic [1:0]  op_q;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic        err_q;
    logic [7:0]  err_cnt_q;
    logic [15:0] regs [NUM_REGS];

    logic        fetch_state;
    logic        latch_cmd;
    logic        latch_data;
    logic        discard;
    logic        exec_go;
    logic        exec_wr;
    logic        exec_err;
    logic [15:0] exec_rdata;
    logic [15:0] rd_mux;
    logic        addr_ok;
    logic        timeout_hit;
    logic        err_inc;

    // Fetch is allowed only in the packet-collecting states
    assign fetch_state = (state_q == S_IDLE) || (state_q == S_GET_CMD) ||
                         (state_q == S_GET_DATA);

    // Register-file read mux and EXEC decode of the latched command
    always_comb begin
        addr_ok    = ({1'b0, addr_q} < NREGS_9);
        rd_mux     = 16'h0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 8'(i)) begin
                rd_mux = regs[i];
            end
        end
        exec_wr    = 1'b0;
        exec_err   = 1'b1;
        exec_rdata = ERR_WORD;
        if (op_q == OP_WRITE && addr_ok) begin
            exec_wr    = 1'b1;
            exec_err   = 1'b0;
            exec_rdata = wdata_q;
        end else if (op_q == OP_READ && addr_ok) begin
            exec_err   = 1'b0;
            exec_rdata = rd_mux;
        end else if (op_q == OP_READ && addr_q == STATUS_ADDR) begin
            exec_err   = 1'b0;
            exec_rdata = status_in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, FIFO handshakes and response word selection
    always_comb begin
        state_d       = state_q;
        cmd_fifo_re   = 1'b0;
        rsp_fifo_we   = 1'b0;
        rsp_fifo_data = 16'h0000;
        latch_cmd     = 1'b0;
        latch_data    = 1'b0;
        discard       = 1'b0;
        exec_go       = 1'b0;

        // One read in flight at most; a pending read blocks the next request
        cmd_fifo_re = fetch_state && !rd_pend_q && !cmd_fifo_empty && !rst;

        case (state_q)
            S_IDLE: begin
                if (rd_pend_q) begin
                    if (cmd_fifo_data == SYNC_WORD) begin
                        state_d = S_GET_CMD;
                    end else begin
                        discard = 1'b1;
                    end
                end
            end
            S_GET_CMD: begin
                if (rd_pend_q) begin
                    latch_cmd = 1'b1;
                    state_d   = (cmd_fifo_data[15:14] == OP_WRITE) ? S_GET_DATA : S_EXEC;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_GET_DATA: begin
                if (rd_pend_q) begin
                    latch_data = 1'b1;
                    state_d    = S_EXEC;
                end else if (timeout_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                exec_go = 1'b1;
                state_d = S_RSP0;
            end
            S_RSP0: begin
                rsp_fifo_data = SYNC_WORD;
                if (!rsp_fifo_full) begin
                    rsp_fifo_we = 1'b1;
                    state_d     = S_RSP1;
                end
            end
            S_RSP1: begin
                rsp_fifo_data = {op_q, 5'b00000, err_q, addr_q};
                if (!rsp_fifo_full) begin
                    rsp_fifo_we = 1'b1;
                    state_d     = S_RSP2;
                end
            end
            S_RSP2: begin
                rsp_fifo_data = rdata_q;
                if (!rsp_fifo_full) begin
                    rsp_fifo_we = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A reset cycle must not push a leftover response word
        if (rst) begin
            rsp_fifo_we   = 1'b0;
            rsp_fifo_data = 16'h0000;
        end
    end

`ifdef CMD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        to_wait;
    logic [15:0] to_cnt_q;

    assign to_wait     = ((state_q == S_GET_CMD) || (state_q == S_GET_DATA)) &&
                         !rd_pend_q && cmd_fifo_empty;
    assign timeout_hit = to_wait && (to_cnt_q == TO_LAST);

    // Idle-wait counter; cleared by every fetched word and outside packet states
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_q <= 16'h0000;
        end else if (!to_wait || timeout_hit) begin
            to_cnt_q <= 16'h0000;
        end else begin
            to_cnt_q <= to_cnt_q + 16'h0001;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign err_inc = discard || (exec_go && exec_err) || timeout_hit;

    // Outstanding-read flag: the word requested last cycle is on cmd_fifo_data now
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
        end else begin
            rd_pend_q <= cmd_fifo_re;
        end
    end

    // Packet field capture and EXEC result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= 2'b00;
            addr_q  <= 8'h00;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            if (latch_cmd) begin
                op_q   <= cmd_fifo_data[15:14];
                addr_q <= cmd_fifo_data[7:0];
            end
            if (latch_data) begin
                wdata_q <= cmd_fifo_data;
            end
            if (exec_go) begin
                rdata_q <= exec_rdata;
                err_q   <= exec_err;
            end
        end
    end

    // Saturating protocol-error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= 8'h00;
        end else if (err_inc && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'h01;
        end
    end

    // Register file, written only by a valid EXEC write
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                regs[i] <= 16'h0000;
            end else if (exec_go && exec_wr && addr_q == 8'(i)) begin
                regs[i] <= wdata_q;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[16*g +: 16] = regs[g];
    end

    assign err_count = err_cnt_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_cmd_interpreter.sv
// Testbench for usb_cmd_interpreter: a command-FIFO model feeds directed
// packets, expected response words go into a scoreboard queue, and a single
// negedge monitor compares response writes and state probes.
module tb_usb_cmd_interpreter;

    localparam int NREGS = 16;
`ifdef CMD_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  cmd_fifo_empty;
    logic [15:0]           cmd_fifo_data = 16'h0000;
    logic                  cmd_fifo_re;
    logic                  rsp_fifo_full = 1'b0;
    logic [15:0]           rsp_fifo_data;
    logic                  rsp_fifo_we;
    logic [15:0]           status_in = 16'h0000;
    logic [NREGS*16-1:0]   reg_out;
    logic [7:0]            err_count;
    logic                  busy;

    usb_cmd_interpreter #(
        .NUM_REGS(NREGS),
        .SYNC_WORD(16'hA5C3),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_fifo_empty(cmd_fifo_empty),
        .cmd_fifo_data(cmd_fifo_data),
        .cmd_fifo_re(cmd_fifo_re),
        .rsp_fifo_full(rsp_fifo_full),
        .rsp_fifo_data(rsp_fifo_data),
        .rsp_fifo_we(rsp_fifo_we),
        .status_in(status_in),
        .reg_out(reg_out),
        .err_count(err_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Command FIFO model (standard read: data appears the cycle after re)
    logic [15:0] cmd_mem [256];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign cmd_fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else if (cmd_fifo_re) begin
            cmd_fifo_data <= cmd_mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    typedef struct {
        string        name;
        int           kind;
        int           idx;
        logic [255:0] exp;
    } probe_t;

    logic [15:0] exp_q [$];
    probe_t      probe_q [$];
    logic        probe_tog  = 1'b0;
    logic        probe_seen = 1'b0;
    logic        done = 1'b0;
    int          checks = 0;
    int          failures = 0;

    // Monitor: scoreboard for response writes plus state probes
    always @(negedge clk) begin
        logic [15:0]  e;
        logic [255:0] act;
        probe_t       p;
        if (rsp_fifo_full) begin
            checks++;
            if (rsp_fifo_we) begin
                failures++;
                $display("FAIL we_while_full: rsp_fifo_we=%0b required 0", rsp_fifo_we);
            end
        end
        if (rsp_fifo_we && !rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected: got %04h, required no write", rsp_fifo_data);
            end else begin
                e = exp_q.pop_front();
                if (rsp_fifo_data !== e) begin
                    failures++;
                    $display("FAIL rsp_word: got %04h, required %04h", rsp_fifo_data, e);
                end
            end
        end
        if (probe_tog != probe_seen) begin
            probe_seen = probe_tog;
            while (probe_q.size() > 0) begin
                p = probe_q.pop_front();
                case (p.kind)
                    0: act = {248'd0, err_count};
                    1: act = {240'd0, reg_out[16*p.idx +: 16]};
                    2: act = {255'd0, busy};
                    3: act = {240'd0, rsp_fifo_data};
                    4: act = 256'(exp_q.size());
                    5: act = {255'd0, rsp_fifo_we};
                    6: act = reg_out;
                    default: act = 256'(p.idx);
                endcase
                checks++;
                if (act !== p.exp) begin
                    failures++;
                    $display("FAIL %s: got %0h, required %0h", p.name, act, p.exp);
                end
                if (p.kind == 4) exp_q.delete();
            end
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0) begin
                failures++;
                $display("FAIL final_pending: got %0d words outstanding, required 0", exp_q.size());
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic push_cmd(input logic [15:0] w);
        cmd_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_rsp(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
    endtask

    task automatic probe(input string name, input int kind, input int idx, input logic [255:0] exp);
        probe_t p;
        p.name = name;
        p.kind = kind;
        p.idx  = idx;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic sync();
        probe_tog = ~probe_tog;
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for every expected word, then confirm nothing is left over
    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        cycles(4);
        probe(name, 4, 0, 256'd0);
        sync();
    endtask

    initial begin
        int found;
        int exp_err;

        // Reset state
        rst = 1'b1;
        cycles(3);
        probe("rst_err_count", 0, 0, 256'd0);
        probe("rst_busy", 2, 0, 256'd0);
        probe("rst_reg_out", 6, 0, 256'd0);
        probe("rst_rsp_data", 3, 0, 256'd0);
        probe("rst_rsp_we", 5, 0, 256'd0);
        sync();
        rst = 1'b0;
        cycles(2);

        // Write then read back register 3
        push_cmd(16'hA5C3); push_cmd(16'h4003); push_cmd(16'h1234);
        push_cmd(16'hA5C3); push_cmd(16'h8003);
        expect_rsp(16'hA5C3, 16'h4003, 16'h1234);
        expect_rsp(16'hA5C3, 16'h8003, 16'h1234);
        drain("wr_rd_drain");
        probe("wr_rd_reg3", 1, 3, 256'h1234);
        probe("wr_rd_err_count", 0, 0, 256'd0);
        sync();

        // Status read and range errors
        status_in = 16'hBEEF;
        push_cmd(16'hA5C3); push_cmd(16'h80FF);
        expect_rsp(16'hA5C3, 16'h80FF, 16'hBEEF);
        drain("status_drain");
        push_cmd(16'hA5C3); push_cmd(16'h8020);
        expect_rsp(16'hA5C3, 16'h8120, 16'hDEAD);
        drain("range_rd_drain");
        probe("range_rd_err_count", 0, 0, 256'd1);
        sync();
        push_cmd(16'hA5C3); push_cmd(16'h41FF); push_cmd(16'h5555);
        expect_rsp(16'hA5C3, 16'h41FF, 16'hDEAD);
        drain("wr_ff_drain");
        probe("wr_ff_err_count", 0, 0, 256'd2);
        probe("wr_ff_regs", 6, 0, {208'd0, 16'h1234, 48'd0});
        sync();

        // Resync after two junk words
        push_cmd(16'h0000); push_cmd(16'h1111); push_cmd(16'hA5C3); push_cmd(16'h8000);
        expect_rsp(16'hA5C3, 16'h8000, 16'h0000);
        drain("resync_drain");
        probe("resync_err_count", 0, 0, 256'd4);
        sync();

        // Invalid op consumes no data word
        push_cmd(16'hA5C3); push_cmd(16'hC005); push_cmd(16'hA5C3); push_cmd(16'h8005);
        expect_rsp(16'hA5C3, 16'hC105, 16'hDEAD);
        expect_rsp(16'hA5C3, 16'h8005, 16'h0000);
        drain("inv_op_drain");
        probe("inv_op_err_count", 0, 0, 256'd5);
        sync();

        // Backpressure during the header word
        push_cmd(16'hA5C3); push_cmd(16'h8003);
        expect_rsp(16'hA5C3, 16'h8003, 16'h1234);
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (rsp_fifo_we && rsp_fifo_data == 16'hA5C3) found = 1;
        end
        probe("bp_rsp0_seen", 7, found, 256'd1);
        sync();
        rsp_fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
            probe("bp_busy", 2, 0, 256'd1);
            probe("bp_data_held", 3, 0, 256'h8003);
            probe("bp_no_we", 5, 0, 256'd0);
            sync();
        end
        rsp_fifo_full = 1'b0;
        drain("bp_drain");

        // Reset in the middle of a write packet
        push_cmd(16'hA5C3); push_cmd(16'h4005);
        cycles(8);
        probe("mid_pkt_busy", 2, 0, 256'd1);
        sync();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(6);
        probe("post_rst_busy", 2, 0, 256'd0);
        probe("post_rst_err_count", 0, 0, 256'd0);
        probe("post_rst_regs", 6, 0, 256'd0);
        probe("post_rst_pending", 4, 0, 256'd0);
        sync();
        exp_err = 0;

`ifdef CMD_TIMEOUT_EN
        // Stall after the sync word until the timeout fires
        push_cmd(16'hA5C3);
        cycles(30);
        probe("timeout_busy", 2, 0, 256'd0);
        probe("timeout_err_count", 0, 0, 256'd1);
        sync();
        exp_err = 1;
`endif

        // Engine still functional after reset
        push_cmd(16'hA5C3); push_cmd(16'h8003);
        expect_rsp(16'hA5C3, 16'h8003, 16'h0000);
        drain("final_rd_drain");
        probe("final_err_count", 0, 0, 256'(exp_err));
        sync();

        done = 1'b1;
        cycles(3);
        $display("FAIL tb_end: monitor did not finish, required summary");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
